// File: rtl/sram_loader.sv
// sram_loader: streams coefficient words into the sram write port,
// one registered write per accepted word at consecutive addresses.
module sram_loader #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] D,
  output logic [ADDR_W-1:0] CADDR,
  output logic              WEN,
  output logic              CEN,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t state;
  state_t state_nx;
  logic   fire;
  logic   start_ok;

  // abort wins over a same-cycle handshake; count never passes DEPTH
  assign fire = (state == LOAD) & in_valid & ~abort
              & (word_cnt != FULL);
  assign start_ok = start & (state != LOAD);

  assign in_ready = (state == LOAD);
  assign done     = (state == DONE);
  assign busy     = (state == LOAD) | ~WEN;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (fire && word_cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // write port and word counter; strobes idle unless a word is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D        <= '0;
      CADDR    <= '0;
      WEN      <= 1'b1;
      CEN      <= 1'b1;
      word_cnt <= '0;
    end else begin
      WEN <= 1'b1;
      CEN <= 1'b1;
      unique case (1'b1)
        fire: begin
          D        <= in_data;
          CADDR    <= word_cnt[ADDR_W-1:0];
          WEN      <= 1'b0;
          CEN      <= 1'b0;
          word_cnt <= word_cnt + 1'b1;
        end
        start_ok: begin
          word_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: randomized streams checked against an expected
// word list and a behavioural model of the sram write port.
module tb_sram_loader;

  localparam int DW    = 20;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] D;
  logic [AW-1:0] CADDR;
  logic          WEN;
  logic          CEN;
  logic          busy;
  logic          done;
  logic [AW:0]   word_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] words [DEPTH];
  int            log_a [$];
  logic [DW-1:0] log_d [$];

  sram_loader #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .D       (D),
    .CADDR   (CADDR),
    .WEN     (WEN),
    .CEN     (CEN),
    .busy    (busy),
    .done    (done),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // sram write port model
  always @(posedge clk) begin
    if (!WEN && !CEN) begin
      mem[CADDR] <= D;
      log_a.push_back(int'(CADDR));
      log_d.push_back(D);
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic a, input logic s);
    in_valid = v;
    in_data  = d;
    abort    = a;
    start    = s;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset;
    int nlog;
    rst = 1'b1;
    start = 0; abort = 0; in_valid = 0; in_data = '0;
    @(negedge clk);
    total++;
    if (WEN !== 1'b1 || CEN !== 1'b1 || in_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || word_cnt !== '0 ||
        D !== '0 || CADDR !== '0) begin
      bad++;
      $display("FAIL reset_state got WEN=%b CEN=%b rdy=%b busy=%b done=%b cnt=%0d exp 1 1 0 0 0 0",
               WEN, CEN, in_ready, busy, done, word_cnt);
    end
    rst = 1'b0;
    step(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, DW'($urandom), 0, 0);
    total++;
    if (WEN !== 1'b0 || word_cnt !== 12'd3) begin
      bad++;
      $display("FAIL pre_reset_load got WEN=%b cnt=%0d exp WEN=0 cnt=3",
               WEN, word_cnt);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (WEN !== 1'b1 || CEN !== 1'b1 || in_ready !== 1'b0 ||
        busy !== 1'b0 || word_cnt !== '0 || D !== '0 ||
        CADDR !== '0) begin
      bad++;
      $display("FAIL async_reset got WEN=%b CEN=%b rdy=%b busy=%b cnt=%0d exp 1 1 0 0 0",
               WEN, CEN, in_ready, busy, word_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    log_a.delete();
    log_d.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, DW'($urandom), 0, 0);
      total++;
      if (in_ready !== 1'b0 || WEN !== 1'b1) begin
        bad++;
        $display("FAIL idle_no_start got rdy=%b WEN=%b exp rdy=0 WEN=1",
                 in_ready, WEN);
      end
    end
    nlog = log_a.size();
    total++;
    if (nlog != 0) begin
      bad++;
      $display("FAIL idle_writes got=%0d exp=0", nlog);
    end
  endtask

  task automatic stream_full(input string name, input int start_at);
    int errs;
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = DW'($urandom);
      step(1, words[i], 0, (i == start_at));
      total++;
      if (WEN !== 1'b0 || CEN !== 1'b0 || CADDR !== AW'(i) ||
          D !== words[i]) begin
        bad++;
        $display("FAIL %s_wr i=%0d got WEN=%b A=%0d D=%h exp WEN=0 A=%0d D=%h",
                 name, i, WEN, CADDR, D, i, words[i]);
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_trail got done=%b busy=%b exp 1 1",
               name, done, busy);
    end
    step(0, '0, 0, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || WEN !== 1'b1 ||
        in_ready !== 1'b0 || word_cnt !== 12'd2048) begin
      bad++;
      $display("FAIL %s_done got done=%b busy=%b WEN=%b rdy=%b cnt=%0d exp 1 0 1 0 2048",
               name, done, busy, WEN, in_ready, word_cnt);
    end
    total++;
    if (log_a.size() != DEPTH) begin
      bad++;
      $display("FAIL %s_wcount got=%0d exp=%0d", name, log_a.size(), DEPTH);
    end
    for (int b = 0; b < 8; b++) begin
      errs = 0;
      for (int w = 0; w < 256; w++)
        if (mem[b*256+w] !== words[b*256+w]) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL %s_bank%0d got=%0d bad words exp=0", name, b, errs);
      end
    end
  endtask

  task automatic test_full_load;
    log_a.delete();
    log_d.delete();
    step(0, '0, 0, 1);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || word_cnt !== '0) begin
      bad++;
      $display("FAIL full_start got rdy=%b busy=%b cnt=%0d exp 1 1 0",
               in_ready, busy, word_cnt);
    end
    stream_full("full", -1);
  endtask

  task automatic test_reload;
    log_a.delete();
    log_d.delete();
    step(0, '0, 0, 1);
    total++;
    if (done !== 1'b0 || in_ready !== 1'b1 || word_cnt !== '0) begin
      bad++;
      $display("FAIL reload_start got done=%b rdy=%b cnt=%0d exp 0 1 0",
               done, in_ready, word_cnt);
    end
    stream_full("reload", 10);
  endtask

  task automatic test_bubbled;
    int n;
    int errs;
    logic v;
    logic [DW-1:0] d;
    log_a.delete();
    log_d.delete();
    step(0, '0, 0, 1);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      v = (c % 3 == 0);
      d = DW'($urandom);
      step(v, d, 0, 0);
      total++;
      if (v) begin
        words[n] = d;
        if (WEN !== 1'b0 || CEN !== 1'b0 || CADDR !== AW'(n) ||
            D !== d) begin
          bad++;
          $display("FAIL bub_wr n=%0d got WEN=%b A=%0d D=%h exp WEN=0 A=%0d D=%h",
                   n, WEN, CADDR, D, n, d);
        end
        n++;
      end else if (WEN !== 1'b1 || CEN !== 1'b1) begin
        bad++;
        $display("FAIL bub_idle c=%0d got WEN=%b CEN=%b exp 1 1",
                 c, WEN, CEN);
      end
    end
    step(0, '0, 1, 0);
    total++;
    if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
        word_cnt !== 12'd100) begin
      bad++;
      $display("FAIL bub_abort got rdy=%b done=%b busy=%b cnt=%0d exp 0 0 0 100",
               in_ready, done, busy, word_cnt);
    end
    errs = (log_a.size() == n) ? 0 : 1;
    for (int k = 0; k < log_a.size() && k < n; k++)
      if (log_a[k] != k || log_d[k] !== words[k]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bub_contig got=%0d errors (%0d writes) exp=0 (%0d writes)",
               errs, log_a.size(), n);
    end
  endtask

  task automatic test_abort;
    int last;
    log_a.delete();
    log_d.delete();
    step(0, '0, 0, 1);
    for (int i = 0; i < 100; i++) step(1, DW'($urandom), 0, 0);
    step(1, DW'($urandom), 1, 0);
    total++;
    if (WEN !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || word_cnt !== 12'd100) begin
      bad++;
      $display("FAIL abort_state got WEN=%b rdy=%b busy=%b done=%b cnt=%0d exp 1 0 0 0 100",
               WEN, in_ready, busy, done, word_cnt);
    end
    step(1, DW'($urandom), 1, 0);
    last = (log_a.size() > 0) ? log_a[$] : -1;
    total++;
    if (log_a.size() != 100 || last != 99 || word_cnt !== 12'd100) begin
      bad++;
      $display("FAIL abort_writes got n=%0d last=%0d cnt=%0d exp n=100 last=99 cnt=100",
               log_a.size(), last, word_cnt);
    end
  endtask

  task automatic test_reset_midload;
    int nlog;
    logic [DW-1:0] d;
    log_a.delete();
    log_d.delete();
    step(0, '0, 0, 1);
    for (int i = 0; i < 500; i++) step(1, DW'($urandom), 0, 0);
    total++;
    if (WEN !== 1'b0 || CADDR !== AW'(499)) begin
      bad++;
      $display("FAIL mid_pre got WEN=%b A=%0d exp WEN=0 A=499", WEN, CADDR);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (WEN !== 1'b1 || CEN !== 1'b1 || word_cnt !== '0 ||
        busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got WEN=%b CEN=%b cnt=%0d busy=%b rdy=%b exp 1 1 0 0 0",
               WEN, CEN, word_cnt, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    nlog = log_a.size();
    total++;
    if (nlog != 499) begin
      bad++;
      $display("FAIL mid_dropped got=%0d exp=499", nlog);
    end
    step(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      d = DW'($urandom);
      step(1, d, 0, 0);
      total++;
      if (WEN !== 1'b0 || CADDR !== AW'(i) || D !== d) begin
        bad++;
        $display("FAIL mid_restart i=%0d got WEN=%b A=%0d D=%h exp WEN=0 A=%0d D=%h",
                 i, WEN, CADDR, D, i, d);
      end
    end
    step(0, '0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reload();
    test_bubbled();
    test_abort();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
